// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and payload types for the hazard/scoreboard block.
package hazard_scoreboard_pkg;

  localparam int unsigned HS_NREG  = 32;
  localparam int unsigned HS_AW    = 5;
  localparam int unsigned HS_NUNIT = 2;
  localparam int unsigned HS_UIW   = 1;
  localparam int unsigned HS_CNTW  = 32;

  // Forwarding mux selects seen by the EXE-stage operand muxes.
  localparam logic [1:0] FWD_NO      = 2'd0;
  localparam logic [1:0] FWD_ALU_EXE = 2'd1;
  localparam logic [1:0] FWD_ALU_MEM = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;

  // Long-latency unit ids.
  localparam int unsigned UNIT_MUL = 0;
  localparam int unsigned UNIT_DIV = 1;

  // Per-cycle pipeline control bundle.
  typedef struct packed {
    logic if_en;
    logic id_en;
    logic exe_en;
    logic mem_en;
    logic wb_en;
    logic id_flush;
    logic exe_flush;
    logic long_issue;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side, long-unit and control signals between datapath and hazard unit.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned AW    = HS_AW,
  parameter int unsigned NUNIT = HS_NUNIT,
  parameter int unsigned UIW   = HS_UIW,
  parameter int unsigned CNTW  = HS_CNTW
);

  logic                  id_valid;
  logic [AW-1:0]         id_rs;
  logic [AW-1:0]         id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_wen;
  logic [AW-1:0]         id_dest;
  logic                  id_is_load;
  logic                  id_is_long;
  logic [UIW-1:0]        id_unit;
  logic                  id_branch_taken;
  logic [NUNIT-1:0]      unit_busy;
  logic [NUNIT-1:0]      unit_done;
  logic [NUNIT*AW-1:0]   unit_dest;
  logic                  mem_ready;

  logic [1:0]            fwd_a_ctrl;
  logic [1:0]            fwd_b_ctrl;
  logic                  fwd_m;
  logic                  if_en;
  logic                  id_en;
  logic                  exe_en;
  logic                  mem_en;
  logic                  wb_en;
  logic                  id_flush;
  logic                  exe_flush;
  logic                  long_issue;
  logic [CNTW-1:0]       stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_dest,
           id_is_load, id_is_long, id_unit, id_branch_taken,
           unit_busy, unit_done, unit_dest, mem_ready,
    input  fwd_a_ctrl, fwd_b_ctrl, fwd_m, if_en, id_en, exe_en, mem_en, wb_en,
           id_flush, exe_flush, long_issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_dest,
           id_is_load, id_is_long, id_unit, id_branch_taken,
           unit_busy, unit_done, unit_dest, mem_ready,
    output fwd_a_ctrl, fwd_b_ctrl, fwd_m, if_en, id_en, exe_en, mem_en, wb_en,
           id_flush, exe_flush, long_issue, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_sb_regs.sv
// Per-register busy/owner scoreboard for long-latency writebacks.
module hazard_scoreboard_sb_regs #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NUNIT = 2,
  parameter int unsigned UIW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [AW-1:0]       set_idx,
  input  logic [UIW-1:0]      set_unit,
  input  logic [NUNIT-1:0]    done,
  input  logic [NUNIT*AW-1:0] done_dest,
  output logic [(1<<AW)-1:0]  busy
);

  localparam int unsigned NSLOT = 1 << AW;
  // Registers that may ever be busy: architectural ones except r0.
  localparam logic [NSLOT-1:0] LIVE = NSLOT'(((64'd1 << NREG) - 64'd1) & ~64'd1);

  logic [NSLOT-1:0] busy_q;
  logic [NSLOT-1:0] busy_nxt;
  logic [UIW-1:0]   owner_q [NSLOT];
  logic             set_ok_c;

  assign set_ok_c = set_en && (set_idx != '0);
  assign busy     = busy_q;

  // Owner-matched completions clear first, then a same-cycle issue re-sets.
  always_comb begin
    busy_nxt = busy_q;
    for (int k = 0; k < NUNIT; k++) begin
      if (done[k] && (owner_q[done_dest[k*AW +: AW]] == UIW'(k))) begin
        busy_nxt[done_dest[k*AW +: AW]] = 1'b0;
      end
    end
    if (set_ok_c) begin
      busy_nxt[set_idx] = 1'b1;
    end
    busy_nxt = busy_nxt & LIVE;
  end

  // Busy bits and owning unit per register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        owner_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_nxt;
      if (set_ok_c) begin
        owner_q[set_idx] <= set_unit;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding, stall/flush control and long-unit scoreboard for the 5-stage pipe.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = HS_NREG,
  parameter int unsigned AW    = HS_AW,
  parameter int unsigned NUNIT = HS_NUNIT,
  parameter int unsigned UIW   = HS_UIW,
  parameter int unsigned CNTW  = HS_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned NSLOT = 1 << AW;

  // EXE/MEM destination shadow; a store is a non-writing short op reading rt.
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] dest;
    logic          is_load;
    logic          is_long;
    logic          use_rt;
    logic [AW-1:0] rt;
  } shadow_t;

  // WB only needs to expose its write for store-data forwarding.
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] dest;
  } wb_shadow_t;

  shadow_t          id_sh_c;
  shadow_t          exe_q;
  shadow_t          mem_q;
  wb_shadow_t       wb_q;
  logic [NSLOT-1:0] busy;
  logic             rs_live_c;
  logic             rt_live_c;
  logic             load_use_c;
  logic             raw_busy_c;
  logic             waw_c;
  logic             unit_full_c;
  logic             hazard_c;
  stage_ctrl_t      ctrl_c;
  logic [1:0]       fwd_a_c;
  logic [1:0]       fwd_b_c;
  logic             fwd_m_c;
  logic [CNTW-1:0]  stall_cnt_q;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input logic live,
                                         input shadow_t exe, input shadow_t mem);
    logic [1:0] sel;
    sel = FWD_NO;
    if (live) begin
      if (exe.valid && exe.wen && !exe.is_load && (exe.dest == src)) begin
        sel = FWD_ALU_EXE;
      end else if (mem.valid && mem.wen && (mem.dest == src)) begin
        sel = mem.is_load ? FWD_MEM : FWD_ALU_MEM;
      end
    end
    return sel;
  endfunction

  // ID fields as they would enter EXE; long ops write back via the scoreboard.
  always_comb begin
    id_sh_c         = '0;
    id_sh_c.valid   = bus.id_valid;
    id_sh_c.wen     = bus.id_wen && !bus.id_is_long;
    id_sh_c.dest    = bus.id_dest;
    id_sh_c.is_load = bus.id_is_load;
    id_sh_c.is_long = bus.id_is_long;
    id_sh_c.use_rt  = bus.id_use_rt;
    id_sh_c.rt      = bus.id_rt;
  end

  // Hazard detection on the instruction sitting in ID.
  always_comb begin
    rs_live_c   = bus.id_use_rs && (bus.id_rs != '0);
    rt_live_c   = bus.id_use_rt && (bus.id_rt != '0);
    load_use_c  = exe_q.valid && exe_q.wen && exe_q.is_load &&
                  ((rs_live_c && (exe_q.dest == bus.id_rs)) ||
                   (rt_live_c && (exe_q.dest == bus.id_rt)));
    raw_busy_c  = (rs_live_c && busy[bus.id_rs]) || (rt_live_c && busy[bus.id_rt]);
    waw_c       = bus.id_wen && busy[bus.id_dest];
    unit_full_c = bus.id_is_long && bus.unit_busy[bus.id_unit];
    hazard_c    = bus.id_valid && (load_use_c || raw_busy_c || waw_c || unit_full_c);
  end

  // Stage enables/flushes: reset, memory wait, hazard, branch, normal flow.
  always_comb begin
    ctrl_c  = '0;
    fwd_a_c = FWD_NO;
    fwd_b_c = FWD_NO;
    fwd_m_c = 1'b0;
    if (rst) begin
      ctrl_c.id_flush  = 1'b1;
      ctrl_c.exe_flush = 1'b1;
    end else begin
      fwd_a_c = fwd_sel(bus.id_rs, rs_live_c, exe_q, mem_q);
      fwd_b_c = fwd_sel(bus.id_rt, rt_live_c, exe_q, mem_q);
      fwd_m_c = mem_q.valid && !mem_q.wen && !mem_q.is_long && mem_q.use_rt &&
                (mem_q.rt != '0) && wb_q.valid && wb_q.wen && (wb_q.dest == mem_q.rt);
      if (!bus.mem_ready) begin
        ctrl_c = '0;
      end else if (hazard_c) begin
        ctrl_c.exe_en    = 1'b1;
        ctrl_c.mem_en    = 1'b1;
        ctrl_c.wb_en     = 1'b1;
        ctrl_c.exe_flush = 1'b1;
      end else begin
        ctrl_c.if_en      = 1'b1;
        ctrl_c.id_en      = 1'b1;
        ctrl_c.exe_en     = 1'b1;
        ctrl_c.mem_en     = 1'b1;
        ctrl_c.wb_en      = 1'b1;
        ctrl_c.id_flush   = bus.id_branch_taken;
        ctrl_c.long_issue = bus.id_valid && bus.id_is_long;
      end
    end
  end

  // EXE/MEM/WB shadows follow the stage enables; a flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (ctrl_c.exe_en) begin
        exe_q <= ctrl_c.exe_flush ? '0 : id_sh_c;
      end
      if (ctrl_c.mem_en) begin
        mem_q <= exe_q;
      end
      if (ctrl_c.wb_en) begin
        wb_q.valid <= mem_q.valid;
        wb_q.wen   <= mem_q.wen;
        wb_q.dest  <= mem_q.dest;
      end
    end
  end

  // Saturating count of cycles lost to hazards or memory waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((hazard_c || !bus.mem_ready) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  hazard_scoreboard_sb_regs #(
    .NREG  (NREG),
    .AW    (AW),
    .NUNIT (NUNIT),
    .UIW   (UIW)
  ) u_sb_regs (
    .clk       (clk),
    .rst       (rst),
    .set_en    (ctrl_c.long_issue && bus.id_wen),
    .set_idx   (bus.id_dest),
    .set_unit  (bus.id_unit),
    .done      (bus.unit_done),
    .done_dest (bus.unit_dest),
    .busy      (busy)
  );

  assign bus.fwd_a_ctrl = fwd_a_c;
  assign bus.fwd_b_ctrl = fwd_b_c;
  assign bus.fwd_m      = fwd_m_c;
  assign bus.if_en      = ctrl_c.if_en;
  assign bus.id_en      = ctrl_c.id_en;
  assign bus.exe_en     = ctrl_c.exe_en;
  assign bus.mem_en     = ctrl_c.mem_en;
  assign bus.wb_en      = ctrl_c.wb_en;
  assign bus.id_flush   = ctrl_c.id_flush;
  assign bus.exe_flush  = ctrl_c.exe_flush;
  assign bus.long_issue = ctrl_c.long_issue;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-cycle reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned CNTW = 4;
  localparam int SAT = (1 << CNTW) - 1;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.AW(5), .NUNIT(2), .UIW(1), .CNTW(CNTW)) bus ();

  hazard_scoreboard #(
    .NREG(32), .AW(5), .NUNIT(2), .UIW(1), .CNTW(CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid, use_rs, use_rt, wen, load, long_op, br;
    int rs, rt, dest, unit;
  } ins_t;

  typedef struct {
    bit valid, wen, load, long_op, store;
    int dest, rt;
  } stg_t;

  typedef struct {
    int fa, fb;
    bit fm, ife, ide, exe, mem, wb, idf, exf, li, haz;
  } exp_t;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 0;

  ins_t     cur;
  bit       cur_mr;
  bit [1:0] cur_dn;
  int       cur_dd [2];
  bit [1:0] cur_ub;
  bit       cur_rst;

  stg_t pipe [3];     // 0 = EXE, 1 = MEM, 2 = WB
  bit   busy_m [32];
  int   owner_m [32];
  int   stalls_m;

  function automatic ins_t nop();
    ins_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t alu(int d, int s, int t);
    ins_t i;
    i = nop();
    i.valid = 1; i.use_rs = 1; i.use_rt = 1; i.wen = 1;
    i.rs = s; i.rt = t; i.dest = d;
    return i;
  endfunction

  function automatic ins_t lw(int t, int base);
    ins_t i;
    i = nop();
    i.valid = 1; i.use_rs = 1; i.wen = 1; i.load = 1;
    i.rs = base; i.rt = t; i.dest = t;
    return i;
  endfunction

  function automatic ins_t sw(int t, int base);
    ins_t i;
    i = nop();
    i.valid = 1; i.use_rs = 1; i.use_rt = 1;
    i.rs = base; i.rt = t;
    return i;
  endfunction

  function automatic ins_t lng(int d, int s, int t, int u);
    ins_t i;
    i = alu(d, s, t);
    i.long_op = 1; i.unit = u;
    return i;
  endfunction

  function automatic ins_t beq(int s, int t);
    ins_t i;
    i = nop();
    i.valid = 1; i.use_rs = 1; i.use_rt = 1; i.br = 1;
    i.rs = s; i.rt = t;
    return i;
  endfunction

  function automatic stg_t empty_stg();
    stg_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stg_t to_stage(ins_t i);
    stg_t s;
    s.valid   = i.valid;
    s.wen     = i.wen && !i.long_op;
    s.load    = i.load;
    s.long_op = i.long_op;
    s.store   = i.valid && !i.wen && !i.long_op && i.use_rt;
    s.dest    = i.dest;
    s.rt      = i.rt;
    return s;
  endfunction

  function automatic int fwd_of(int s, bit used);
    if (!used || s == 0) return 0;
    if (pipe[0].valid && pipe[0].wen && !pipe[0].load && pipe[0].dest == s) return 1;
    if (pipe[1].valid && pipe[1].wen && pipe[1].dest == s) return pipe[1].load ? 3 : 2;
    return 0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit rs_l, rt_l, lu, rb, waw, uf;
    e = '{default: 0};
    if (cur_rst) begin
      e.idf = 1; e.exf = 1;
      return e;
    end
    e.fa = fwd_of(cur.rs, cur.use_rs);
    e.fb = fwd_of(cur.rt, cur.use_rt);
    e.fm = pipe[1].valid && pipe[1].store && pipe[1].rt != 0 &&
           pipe[2].valid && pipe[2].wen && pipe[2].dest == pipe[1].rt;
    rs_l = cur.use_rs && cur.rs != 0;
    rt_l = cur.use_rt && cur.rt != 0;
    lu   = pipe[0].valid && pipe[0].load && pipe[0].wen &&
           ((rs_l && pipe[0].dest == cur.rs) || (rt_l && pipe[0].dest == cur.rt));
    rb   = (rs_l && busy_m[cur.rs]) || (rt_l && busy_m[cur.rt]);
    waw  = cur.wen && busy_m[cur.dest];
    uf   = cur.long_op && cur_ub[cur.unit];
    e.haz = cur.valid && (lu || rb || waw || uf);
    if (!cur_mr) begin
      // memory wait: everything frozen
    end else if (e.haz) begin
      e.exe = 1; e.mem = 1; e.wb = 1; e.exf = 1;
    end else begin
      e.ife = 1; e.ide = 1; e.exe = 1; e.mem = 1; e.wb = 1;
      e.idf = cur.br;
      e.li  = cur.valid && cur.long_op;
    end
    return e;
  endfunction

  // Advance the reference state on each rising edge.
  always @(posedge clk) begin : model_upd
    exp_t e;
    e = model_eval();
    if (cur_rst) begin
      for (int r = 0; r < 32; r++) begin busy_m[r] = 0; owner_m[r] = 0; end
      for (int s = 0; s < 3; s++) pipe[s] = empty_stg();
      stalls_m = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (cur_dn[k] && owner_m[cur_dd[k]] == k) busy_m[cur_dd[k]] = 0;
      if (e.li && cur.wen && cur.dest != 0) begin
        busy_m[cur.dest] = 1;
        owner_m[cur.dest] = cur.unit;
      end
      if (e.wb)  pipe[2] = pipe[1];
      if (e.mem) pipe[1] = pipe[0];
      if (e.exe) pipe[0] = e.exf ? empty_stg() : to_stage(cur);
      if ((e.haz || !cur_mr) && stalls_m < SAT) stalls_m++;
    end
  end

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (cmp_on) begin
      e = model_eval();
      check("fwd_a_ctrl", int'(bus.fwd_a_ctrl), e.fa);
      check("fwd_b_ctrl", int'(bus.fwd_b_ctrl), e.fb);
      check("fwd_m",      int'(bus.fwd_m),      int'(e.fm));
      check("if_en",      int'(bus.if_en),      int'(e.ife));
      check("id_en",      int'(bus.id_en),      int'(e.ide));
      check("exe_en",     int'(bus.exe_en),     int'(e.exe));
      check("mem_en",     int'(bus.mem_en),     int'(e.mem));
      check("wb_en",      int'(bus.wb_en),      int'(e.wb));
      check("id_flush",   int'(bus.id_flush),   int'(e.idf));
      check("exe_flush",  int'(bus.exe_flush),  int'(e.exf));
      check("long_issue", int'(bus.long_issue), int'(e.li));
      check("stall_cnt",  int'(bus.stall_cnt),  stalls_m);
    end
  end

  task automatic drive();
    rst                 = cur_rst;
    bus.id_valid        = cur.valid;
    bus.id_rs           = 5'(cur.rs);
    bus.id_rt           = 5'(cur.rt);
    bus.id_use_rs       = cur.use_rs;
    bus.id_use_rt       = cur.use_rt;
    bus.id_wen          = cur.wen;
    bus.id_dest         = 5'(cur.dest);
    bus.id_is_load      = cur.load;
    bus.id_is_long      = cur.long_op;
    bus.id_unit         = 1'(cur.unit);
    bus.id_branch_taken = cur.br;
    bus.unit_busy       = cur_ub;
    bus.unit_done       = cur_dn;
    bus.unit_dest       = {5'(cur_dd[1]), 5'(cur_dd[0])};
    bus.mem_ready       = cur_mr;
  endtask

  // One cycle of stimulus; returns at the following falling edge.
  task automatic step(input ins_t i, input bit mr = 1, input bit [1:0] dn = 2'b00,
                      input int d0 = 0, input int d1 = 0, input bit [1:0] ub = 2'b00,
                      input bit r = 0);
    @(posedge clk);
    #1;
    cur = i; cur_mr = mr; cur_dn = dn; cur_dd[0] = d0; cur_dd[1] = d1;
    cur_ub = ub; cur_rst = r;
    drive();
    @(negedge clk);
  endtask

  initial begin
    cur = nop(); cur_mr = 1; cur_dn = 0; cur_dd[0] = 0; cur_dd[1] = 0;
    cur_ub = 0; cur_rst = 1; stalls_m = 0;
    for (int s = 0; s < 3; s++) pipe[s] = empty_stg();
    for (int r = 0; r < 32; r++) begin busy_m[r] = 0; owner_m[r] = 0; end
    drive();

    // Reset
    step(nop(), 1, 0, 0, 0, 0, 1);
    cmp_on = 1;
    step(nop(), 1, 0, 0, 0, 0, 1);
    check("rst_if_en", int'(bus.if_en), 0);
    check("rst_id_flush", int'(bus.id_flush), 1);
    check("rst_exe_flush", int'(bus.exe_flush), 1);
    check("rst_fwd_a", int'(bus.fwd_a_ctrl), int'(FWD_NO));

    // Load-use: one bubble, then MEM forwarding on both operands
    step(lw(1, 0));
    check("lw_stall_cnt0", int'(bus.stall_cnt), 0);
    step(alu(2, 1, 1));
    check("lu_if_en", int'(bus.if_en), 0);
    check("lu_id_en", int'(bus.id_en), 0);
    check("lu_exe_flush", int'(bus.exe_flush), 1);
    step(alu(2, 1, 1));
    check("lu_stall_cnt", int'(bus.stall_cnt), 1);
    check("lu_fwd_a", int'(bus.fwd_a_ctrl), int'(FWD_MEM));
    check("lu_fwd_b", int'(bus.fwd_b_ctrl), int'(FWD_MEM));

    // ALU forwarding from EXE, then from MEM across a nop
    step(alu(1, 2, 3));
    step(alu(4, 1, 5));
    check("exe_fwd_a", int'(bus.fwd_a_ctrl), int'(FWD_ALU_EXE));
    check("exe_fwd_b", int'(bus.fwd_b_ctrl), int'(FWD_NO));
    check("exe_if_en", int'(bus.if_en), 1);
    step(alu(1, 2, 3));
    step(nop());
    step(alu(4, 1, 5));
    check("mem_fwd_a", int'(bus.fwd_a_ctrl), int'(FWD_ALU_MEM));

    // Store data forwarded from WB
    step(alu(6, 2, 3));
    step(sw(6, 0));
    check("sw_fwd_b", int'(bus.fwd_b_ctrl), int'(FWD_ALU_EXE));
    step(nop());
    step(nop());
    check("fwd_m_set", int'(bus.fwd_m), 1);
    step(nop());
    check("fwd_m_clr", int'(bus.fwd_m), 0);

    // Divide to $8 then a dependent add: stalls through done cycle
    step(lng(8, 2, 3, UNIT_DIV));
    check("div_issue", int'(bus.long_issue), 1);
    for (int c = 0; c < 9; c++) step(alu(9, 8, 0));
    step(alu(9, 8, 0), 1, 2'b10, 0, 8);
    check("div_done_stall", int'(bus.if_en), 0);
    step(alu(9, 8, 0));
    check("div_release", int'(bus.if_en), 1);
    check("div_stall_cnt", int'(bus.stall_cnt), 11);

    // WAW between units; late completion from the old owner is ignored
    step(lng(8, 1, 2, UNIT_MUL));
    step(lng(8, 1, 2, UNIT_DIV));
    check("waw_stall", int'(bus.if_en), 0);
    check("waw_no_issue", int'(bus.long_issue), 0);
    step(lng(8, 1, 2, UNIT_DIV), 1, 2'b01, 8, 0);
    check("waw_done_stall", int'(bus.if_en), 0);
    step(lng(8, 1, 2, UNIT_DIV));
    check("waw_issue", int'(bus.long_issue), 1);
    step(nop(), 1, 2'b01, 8, 0);
    step(alu(9, 8, 0));
    check("stale_done_ignored", int'(bus.if_en), 0);
    step(alu(9, 8, 0), 1, 2'b10, 0, 8);
    step(alu(9, 8, 0));
    check("owner_release", int'(bus.if_en), 1);
    check("stall_sat_reach", int'(bus.stall_cnt), SAT);

    // Memory wait freezes all stages; completions still retire
    step(lng(10, 1, 2, UNIT_MUL));
    step(lw(3, 0), 0, 2'b01, 10, 0);
    check("mw_if_en", int'(bus.if_en), 0);
    check("mw_wb_en", int'(bus.wb_en), 0);
    check("mw_exe_flush", int'(bus.exe_flush), 0);
    step(lw(3, 0), 0);
    step(lw(3, 0), 0);
    check("mw_id_flush", int'(bus.id_flush), 0);
    step(lw(3, 0));
    step(alu(11, 10, 0));
    check("mw_busy_cleared", int'(bus.if_en), 1);
    check("stall_sat_hold", int'(bus.stall_cnt), SAT);

    // Taken branch squashes one fetched slot
    step(beq(1, 2));
    check("br_id_flush", int'(bus.id_flush), 1);
    check("br_if_en", int'(bus.if_en), 1);
    step(nop());
    check("br_flush_clr", int'(bus.id_flush), 0);

    // Reset in the middle of a scoreboard stall
    step(lng(12, 1, 2, UNIT_DIV));
    step(alu(13, 12, 0));
    step(alu(13, 12, 0));
    check("pre_rst_stall", int'(bus.if_en), 0);
    step(alu(13, 12, 0), 1, 0, 0, 0, 0, 1);
    step(alu(13, 12, 0));
    check("post_rst_if_en", int'(bus.if_en), 1);
    check("post_rst_stall_cnt", int'(bus.stall_cnt), 0);
    check("post_rst_fwd_a", int'(bus.fwd_a_ctrl), int'(FWD_NO));

    // Target unit busy blocks issue
    step(lng(14, 1, 2, UNIT_DIV), 1, 0, 0, 0, 2'b10);
    check("ubusy_stall", int'(bus.if_en), 0);
    check("ubusy_no_issue", int'(bus.long_issue), 0);
    step(lng(14, 1, 2, UNIT_DIV));
    check("ubusy_issue", int'(bus.long_issue), 1);
    step(nop(), 1, 2'b10, 0, 14);
    step(nop());
    step(nop());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed forwarding/stall logic of the 5-stage MIPS pipeline. It adds long-latency functional units (multiplier, divider) that complete out of order, using a per-register scoreboard. It tracks EXE/MEM/WB destination shadows and generates forwarding selects, stage enables/flushes and a stall counter for the datapath. It sits beside the datapath and controller and consumes ID-stage decode fields.

Parameters:
NREG, 32, number of architectural registers (register 0 hard-wired zero)
AW, 5, register address width, must satisfy 2**AW >= NREG
NUNIT, 2, number of long-latency units
UIW, 1, unit-id width, must satisfy 2**UIW >= NUNIT
CNTW, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs / id_rt  in  AW each  ID source register addresses
id_use_rs / id_use_rt  in  1 each  source actually read
id_wen  in  1  ID instruction writes a register
id_dest  in  AW  ID destination
id_is_load  in  1  ID instruction is a load
id_is_long  in  1  ID instruction issues to a long unit
id_unit  in  UIW  target long unit
id_branch_taken  in  1  ID resolves a taken branch/jump
unit_busy  in  NUNIT  long unit cannot accept
unit_done  in  NUNIT  long unit writes back this cycle
unit_dest  in  NUNIT*AW  destination per completing unit
mem_ready  in  1  data memory has completed its access
fwd_a_ctrl / fwd_b_ctrl  out  2 each  FWD_NO / FWD_ALU_EXE / FWD_ALU_MEM / FWD_MEM
fwd_m  out  1  store data in MEM taken from WB
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
id_flush, exe_flush  out  1 each  synchronous stage resets (bubble insertion)
long_issue  out  1  issue strobe to unit id_unit
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- During rst:
  - all busy bits, owners and EXE/MEM/WB shadows are cleared.
  - stall_cnt=0; all enables=0; id_flush=exe_flush=1; long_issue=0; fwd_*=FWD_NO; fwd_m=0.
- Reset deasserted mid-operation: the first cycle after reset runs with empty shadows.
- Shadows (exe/mem/wb: valid, wen, dest, is_load, is_long):
  - Advance when the corresponding *_en=1.
  - A flush loads valid=0.
  - Long instructions enter the shadows with wen=0 because they write back via the scoreboard.
- Forwarding, per source s, only when s!=0 and the source is used. Priority order:
  1. EXE non-load wen match -> FWD_ALU_EXE.
  2. MEM non-load match -> FWD_ALU_MEM.
  3. MEM load match -> FWD_MEM.
  4. Otherwise FWD_NO; WB is covered by regfile write-through.
- fwd_m=1 when a MEM store's rt equals the WB dest and WB wen=1.
- hazard is the OR of:
  - (a) load-use: an EXE load whose dest matches a used source;
  - (b) a used source whose busy bit is set;
  - (c) WAW: id_wen and dest busy;
  - (d) id_is_long and unit_busy[id_unit].
  - All conditions qualified by id_valid.
- Busy bits are registered, so a source released by unit_done stalls through the done cycle and issues the next cycle.
- Priority of control outputs:
  - mem_ready=0: all enables=0, no flushes, long_issue=0. The scoreboard still processes unit_done.
  - else hazard: if_en=id_en=0, exe_flush=1, mem_en=wb_en=1, long_issue=0.
  - else id_branch_taken: all enables=1, id_flush=1 (squash the fetched slot).
  - else all enables=1, no flushes. long_issue=id_valid&id_is_long.
- Scoreboard:
  - long_issue sets busy[id_dest] (if id_wen and id_dest!=0) and records owner=id_unit.
  - unit_done[k] clears busy[unit_dest[k]] only when owner==k.
  - Set and clear of the same register in one cycle: set wins.
  - Multiple completions in one cycle are processed independently.
- stall_cnt increments on any cycle with hazard or mem_ready=0, and saturates at all-ones.

Decomposition:
- FWD_* codes are already in mips_define.vh.
- Add UNIT_MUL=0 and UNIT_DIV=1 to the same shared define file.
- Split out one sub-module, sb_regs: busy/owner array with issue-set/done-clear ports, set-wins rule, register 0 never busy, outputs busy vector.

Test Plan:
- add $1,$2,$3 then sub $4,$1,$5 -> fwd_a_ctrl=FWD_ALU_EXE, no stall; same with one nop between -> FWD_ALU_MEM.
- lw $1,0($0) then add $2,$1,$1 -> one stall cycle (if_en=id_en=0, exe_flush=1, stall_cnt=1), then fwd_a_ctrl=fwd_b_ctrl=FWD_MEM.
- div (unit 1) to $8, then add $9,$8,$0 -> stalls until unit_done[1] with dest 8, issues the cycle after; a 10-cycle divide gives stall_cnt=11.
- mul to $8 (unit 0), then div to $8 -> WAW stall. unit_done[0]=8 clears busy; div issues; a late unit_done[0] with dest 8 is ignored because owner=1.
- mem_ready held 0 for 3 cycles during lw -> all enables 0 for 3 cycles, no flush; a simultaneous unit_done clears busy.
- Taken beq with no hazard -> id_flush=1 for one cycle; rst asserted mid-stall -> next cycle busy=0 and stall_cnt=0.
